enemy_formation: RTL and testbench



---
 rtl/enemy_formation.sv | 241 ++++++++++++++++++++++++
 tb/tb_enemy_formation.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_formation.sv
// enemy_formation: COLS x ROWS marching enemy grid.
// Owns the alive bitmap, the formation origin (base_x/base_y), marching
// direction, edge-triggered descent, kill-driven speed-up, collision against
// the player shot, and the wave-clear / invasion flags.
//
// Handshake: shot_valid is a level from the munition block. A shot that lands
// in an alive enemy box is consumed by a one-cycle shot_hit pulse in the next
// cycle. shot_valid is ignored while shot_hit is high, so a single shot can
// never kill twice. There is no back-pressure; shot_hit is the only response.
module enemy_formation #(
    parameter int COLS        = 8,
    parameter int ROWS        = 3,
    parameter int X0          = 150,
    parameter int Y0          = 40,
    parameter int DX          = 60,
    parameter int DY          = 50,
    parameter int SPR_W       = 16,
    parameter int SPR_H       = 16,
    parameter int STEP_X      = 20,
    parameter int STEP_Y      = 25,
    parameter int X_MAX       = 639,
    parameter int Y_LIMIT     = 440,
    parameter int PERIOD_BASE = 25000000,
    parameter int PERIOD_DEC  = 600000,
    parameter int PERIOD_MIN  = 2000000
) (
    input  logic                 clk,
    input  logic                 reset,        // asynchronous, active-low
    input  logic                 start,
    input  logic                 shot_valid,
    input  logic [10:0]          shot_x,
    input  logic [10:0]          shot_y,
    output logic                 shot_hit,
    output logic [7:0]           hit_index,
    output logic [COLS*ROWS-1:0] alive,
    output logic [7:0]           alive_count,
    output logic [10:0]          base_x,
    output logic [10:0]          base_y,
    output logic                 dir,
    output logic                 step,
    output logic                 wave_clear,
    output logic                 invaded,
    output logic [1:0]           state_dbg
);

    localparam int N = COLS * ROWS;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MARCH   = 2'd1,
        S_CLEAR   = 2'd2,
        S_INVADED = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Tick timing
    logic [31:0] tick_cnt;
    logic [31:0] period;
    logic [47:0] dec_total;
    logic [7:0]  kills;
    logic        tick;

    // Formation extents, taken from the current (pre-kill) bitmap
    logic [COLS-1:0] col_alive;
    logic [ROWS-1:0] row_alive;
    logic [3:0]      left_col;
    logic [3:0]      right_col;
    logic [2:0]      low_row;

    // Move decision
    logic [10:0] left_x;
    logic [10:0] right_edge;
    logic [10:0] desc_y;
    logic [10:0] bottom_y;
    logic        descend;
    logic        invade;

    // Collision
    logic         hit_found;
    logic [7:0]   hit_idx;
    logic [N-1:0] kill_mask;
    logic         kill;
    logic         last_kill;

    // True when p lies in the half-open span [lo, lo+size), 11-bit wrap.
    function automatic logic in_span(input logic [10:0] p,
                                     input logic [10:0] lo,
                                     input logic [10:0] size);
        logic [10:0] hi;
        hi = lo + size;
        return (p >= lo) && (p < hi);
    endfunction

    // Population count of the alive bitmap
    always_comb begin
        alive_count = '0;
        for (int i = 0; i < N; i++) begin
            alive_count = alive_count + {7'd0, alive[i]};
        end
    end

    // Tick period shrinks with every kill down to a floor; recomputed each cycle
    always_comb begin
        kills     = 8'(N) - alive_count;
        dec_total = 48'(kills) * 48'(PERIOD_DEC);
        if (48'(PERIOD_BASE) > dec_total + 48'(PERIOD_MIN)) begin
            period = 32'(48'(PERIOD_BASE) - dec_total);
        end else begin
            period = 32'(PERIOD_MIN);
        end
        // >= rather than == so a period that just shrank below the count still fires
        tick = (state == S_MARCH) && (tick_cnt >= period - 32'd1);
    end

    // Leftmost / rightmost alive column and bottom-most alive row
    always_comb begin
        col_alive = '0;
        row_alive = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                col_alive[c] = col_alive[c] | alive[r*COLS + c];
                row_alive[r] = row_alive[r] | alive[r*COLS + c];
            end
        end
        left_col  = '0;
        right_col = '0;
        low_row   = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (col_alive[c]) left_col = 4'(c);
        end
        for (int c = 0; c < COLS; c++) begin
            if (col_alive[c]) right_col = 4'(c);
        end
        for (int r = 0; r < ROWS; r++) begin
            if (row_alive[r]) low_row = 3'(r);
        end
    end

    // Edge test for the next move and the invasion test after a descent
    always_comb begin
        left_x     = base_x + 11'(int'(left_col) * DX);
        right_edge = base_x + 11'(int'(right_col) * DX) + 11'(SPR_W) + 11'(STEP_X);
        descend    = dir ? (left_x < 11'(STEP_X)) : (right_edge > 11'(X_MAX));
        desc_y     = base_y + 11'(STEP_Y);
        bottom_y   = desc_y + 11'(int'(low_row) * DY) + 11'(SPR_H);
        invade     = descend && (bottom_y >= 11'(Y_LIMIT));
    end

    // Shot-vs-enemy search; ascending index scan so the lowest index wins
    always_comb begin
        hit_found = 1'b0;
        hit_idx   = '0;
        kill_mask = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (!hit_found && alive[r*COLS + c]
                    && in_span(shot_x, base_x + 11'(c * DX), 11'(SPR_W))
                    && in_span(shot_y, base_y + 11'(r * DY), 11'(SPR_H))) begin
                    hit_found              = 1'b1;
                    hit_idx                = 8'(r*COLS + c);
                    kill_mask[r*COLS + c]  = 1'b1;
                end
            end
        end
        kill      = (state == S_MARCH) && shot_valid && !shot_hit && hit_found;
        last_kill = kill && (alive_count == 8'd1);
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: start always reloads; a final kill beats a pending invasion
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = S_MARCH;
        end else if (state == S_MARCH) begin
            if (last_kill) begin
                state_next = S_CLEAR;
            end else if (tick && invade) begin
                state_next = S_INVADED;
            end
        end
    end

    assign wave_clear = (state == S_CLEAR);
    assign invaded    = (state == S_INVADED);
    assign state_dbg  = state;

    // Formation datapath: reload, kill, tick counter and march/descend
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alive     <= '0;
            base_x    <= 11'(X0);
            base_y    <= 11'(Y0);
            dir       <= 1'b0;
            tick_cnt  <= '0;
            shot_hit  <= 1'b0;
            hit_index <= '0;
            step      <= 1'b0;
        end else begin
            step     <= 1'b0;
            shot_hit <= 1'b0;
            if (start) begin
                alive    <= '1;
                base_x   <= 11'(X0);
                base_y   <= 11'(Y0);
                dir      <= 1'b0;
                tick_cnt <= '0;
            end else if (state == S_MARCH) begin
                if (kill) begin
                    alive     <= alive & ~kill_mask;
                    shot_hit  <= 1'b1;
                    hit_index <= hit_idx;
                end
                tick_cnt <= tick ? 32'd0 : tick_cnt + 32'd1;
                // The move uses the pre-kill extents; the last kill cancels it
                if (tick && !last_kill) begin
                    step <= 1'b1;
                    if (descend) begin
                        base_y <= desc_y;
                        dir    <= ~dir;
                    end else if (dir) begin
                        base_x <= base_x - 11'(STEP_X);
                    end else begin
                        base_x <= base_x + 11'(STEP_X);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_enemy_formation.sv
// Testbench for enemy_formation: directed steps plus randomized shots, checked
// against a behavioural model of the formation rules.
module tb_enemy_formation;

  localparam int COLS    = 8;
  localparam int ROWS    = 3;
  localparam int N       = COLS * ROWS;
  localparam int X0      = 150;
  localparam int Y0      = 40;
  localparam int DX      = 60;
  localparam int DY      = 50;
  localparam int SPR_W   = 16;
  localparam int SPR_H   = 16;
  localparam int STEP_X  = 20;
  localparam int STEP_Y  = 25;
  localparam int X_MAX   = 639;
  localparam int Y_LIMIT = 440;
  localparam int PB      = 4;
  localparam int PD      = 1;
  localparam int PM      = 2;

  // clock / reset block
  logic clk;
  logic reset;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // DUT A (main) signals
  logic         start, shot_valid;
  logic [10:0]  shot_x, shot_y;
  logic         shot_hit, dir, step, wave_clear, invaded;
  logic [7:0]   hit_index, alive_count;
  logic [N-1:0] alive;
  logic [10:0]  base_x, base_y;
  logic [1:0]   state_dbg;

  // DUT B (low invasion line) signals
  logic         start_b, shot_valid_b;
  logic         shot_hit_b, dir_b, step_b, wave_clear_b, invaded_b;
  logic [7:0]   hit_index_b, alive_count_b;
  logic [N-1:0] alive_b;
  logic [10:0]  base_x_b, base_y_b;
  logic [1:0]   state_dbg_b;

  enemy_formation #(.PERIOD_BASE(PB), .PERIOD_DEC(PD), .PERIOD_MIN(PM)) dut (
    .clk(clk), .reset(reset), .start(start), .shot_valid(shot_valid),
    .shot_x(shot_x), .shot_y(shot_y), .shot_hit(shot_hit), .hit_index(hit_index),
    .alive(alive), .alive_count(alive_count), .base_x(base_x), .base_y(base_y),
    .dir(dir), .step(step), .wave_clear(wave_clear), .invaded(invaded),
    .state_dbg(state_dbg)
  );

  enemy_formation #(.Y_LIMIT(100), .PERIOD_BASE(PB), .PERIOD_DEC(PD), .PERIOD_MIN(PM)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .shot_valid(shot_valid_b),
    .shot_x(shot_x), .shot_y(shot_y), .shot_hit(shot_hit_b), .hit_index(hit_index_b),
    .alive(alive_b), .alive_count(alive_count_b), .base_x(base_x_b), .base_y(base_y_b),
    .dir(dir_b), .step(step_b), .wave_clear(wave_clear_b), .invaded(invaded_b),
    .state_dbg(state_dbg_b)
  );

  // scoreboard counters
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // behavioural reference model of DUT A
  logic [N-1:0] m_alive;
  int m_bx, m_by, m_cnt, m_hidx;
  bit m_dir, m_run, m_clr, m_inv, m_hit, m_stp;

  function automatic int popc(input logic [N-1:0] v);
    int n = 0;
    for (int i = 0; i < N; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic bit in_enemy(input int i, input int x, input int y);
    int lx, ly, hx, hy;
    lx = (m_bx + (i % COLS) * DX) % 2048;
    ly = (m_by + (i / COLS) * DY) % 2048;
    hx = (lx + SPR_W) % 2048;
    hy = (ly + SPR_H) % 2048;
    return (x >= lx) && (x < hx) && (y >= ly) && (y < hy);
  endfunction

  task automatic model_reset();
    m_alive = '0; m_bx = X0; m_by = Y0; m_dir = 1'b0; m_cnt = 0;
    m_run = 1'b0; m_clr = 1'b0; m_inv = 1'b0; m_hit = 1'b0; m_hidx = 0; m_stp = 1'b0;
  endtask

  task automatic model_cycle(input bit st, input bit sv, input int sx, input int sy);
    longint p;
    int hit, lc, rc, lowr;
    bit tick, desc;
    logic [N-1:0] pre;
    m_stp = 1'b0;
    if (st) begin
      m_alive = '1; m_bx = X0; m_by = Y0; m_dir = 1'b0; m_cnt = 0;
      m_run = 1'b1; m_clr = 1'b0; m_inv = 1'b0; m_hit = 1'b0;
      return;
    end
    if (!m_run) begin
      m_hit = 1'b0;
      return;
    end
    p = longint'(PB) - longint'(N - popc(m_alive)) * PD;
    if (p < PM) p = PM;
    hit = -1;
    if (sv && !m_hit) begin
      for (int i = 0; i < N; i++) begin
        if (hit < 0 && m_alive[i] && in_enemy(i, sx, sy)) hit = i;
      end
    end
    tick  = (longint'(m_cnt) + 1 >= p);
    m_cnt = tick ? 0 : m_cnt + 1;
    pre   = m_alive;
    m_hit = (hit >= 0);
    if (hit >= 0) begin
      m_alive[hit] = 1'b0;
      m_hidx = hit;
    end
    if (popc(m_alive) == 0) begin
      m_run = 1'b0; m_clr = 1'b1;
      return;
    end
    if (tick) begin
      m_stp = 1'b1;
      lc = COLS; rc = -1; lowr = -1;
      for (int i = 0; i < N; i++) begin
        if (pre[i]) begin
          if (i % COLS < lc) lc = i % COLS;
          if (i % COLS > rc) rc = i % COLS;
          if (i / COLS > lowr) lowr = i / COLS;
        end
      end
      if (!m_dir) desc = ((m_bx + rc * DX + SPR_W + STEP_X) % 2048) > X_MAX;
      else        desc = ((m_bx + lc * DX) % 2048) < STEP_X;
      if (desc) begin
        m_by  = (m_by + STEP_Y) % 2048;
        m_dir = !m_dir;
        if (((m_by + lowr * DY + SPR_H) % 2048) >= Y_LIMIT) begin
          m_run = 1'b0; m_inv = 1'b1;
        end
      end else if (m_dir) begin
        m_bx = (m_bx - STEP_X + 2048) % 2048;
      end else begin
        m_bx = (m_bx + STEP_X) % 2048;
      end
    end
  endtask

  task automatic check_model();
    chk("shot_hit", shot_hit, m_hit);
    chk("hit_index", hit_index, m_hidx);
    chk("alive", alive, m_alive);
    chk("alive_count", alive_count, popc(m_alive));
    chk("base_x", base_x, m_bx);
    chk("base_y", base_y, m_by);
    chk("dir", dir, m_dir);
    chk("step", step, m_stp);
    chk("wave_clear", wave_clear, m_clr);
    chk("invaded", invaded, m_inv);
  endtask

  // driver: one clock of stimulus on DUT A, model advanced alongside
  task automatic cyc(input bit st, input bit sv, input int sx, input int sy);
    start = st; shot_valid = sv; shot_x = 11'(sx); shot_y = 11'(sy);
    model_cycle(st, sv, sx % 2048, sy % 2048);
    @(posedge clk); #1;
    check_model();
  endtask

  // shot at an offset inside enemy i at the model's current position
  task automatic shoot(input int i, input int ox, input int oy);
    cyc(1'b0, 1'b1, (m_bx + (i % COLS) * DX + ox) % 2048, (m_by + (i / COLS) * DY + oy) % 2048);
  endtask

  int seen, first_k, steps_b;
  int q[$];

  initial begin
    reset = 1'b0; start = 1'b0; shot_valid = 1'b0; shot_x = '0; shot_y = '0;
    start_b = 1'b0; shot_valid_b = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_base_x", base_x, 150);
    chk("rst_base_y", base_y, 40);
    chk("rst_alive", alive, 0);
    chk("rst_count", alive_count, 0);
    chk("rst_flags", {shot_hit, step, dir, wave_clear, invaded}, 0);
    reset = 1'b1;

    // idle: no movement and no collision before start
    for (int k = 0; k < 6; k++) cyc(1'b0, 1'b1, $urandom_range(0, 700), $urandom_range(0, 500));

    // low invasion line instance: first descent invades and freezes
    start_b = 1'b1;
    cyc(1'b0, 1'b0, 0, 0);
    start_b = 1'b0;
    chk("b_start_x", base_x_b, 150);
    chk("b_start_alive", alive_count_b, 24);
    for (int k = 0; k < 40 && !invaded_b; k++) cyc(1'b0, 1'b0, 0, 0);
    chk("b_invaded", invaded_b, 1);
    chk("b_desc_y", base_y_b, 65);
    chk("b_desc_x", base_x_b, 190);
    chk("b_desc_dir", dir_b, 1);
    steps_b = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b0, 0, 0);
      steps_b += int'(step_b);
    end
    chk("b_frozen_steps", steps_b, 0);
    chk("b_frozen_x", base_x_b, 190);
    chk("b_frozen_y", base_y_b, 65);
    chk("b_frozen_alive", alive_b, 24'hFFFFFF);
    chk("b_no_clear", {wave_clear_b, shot_hit_b, 8'(hit_index_b)}, 0);

    // march: step every 4 clocks, descent at base_x=190
    cyc(1'b1, 1'b0, 0, 0);
    seen = 0; first_k = -1;
    for (int k = 0; k < 20 && seen < 3; k++) begin
      cyc(1'b0, 1'b0, 0, 0);
      if (step) begin
        seen++;
        if (seen == 1) begin first_k = k; chk("march_x1", base_x, 170); end
        if (seen == 2) chk("march_x2", base_x, 190);
      end
    end
    chk("first_step_cycle", first_k, 3);
    chk("desc_y", base_y, 65);
    chk("desc_x", base_x, 190);
    chk("desc_dir", dir, 1);

    // directed shot on enemy 10, then the same shot held
    cyc(1'b1, 1'b0, 0, 0);
    cyc(1'b0, 1'b1, 150 + 2*60 + 3, 40 + 1*50 + 3);
    chk("hit_pulse", shot_hit, 1);
    chk("hit_idx10", hit_index, 10);
    chk("alive10", alive[10], 0);
    chk("count23", alive_count, 23);
    cyc(1'b0, 1'b1, 150 + 2*60 + 3, 40 + 1*50 + 3);
    chk("no_double_hit", shot_hit, 0);
    cyc(1'b0, 1'b1, 150 + 2*60 + 3, 40 + 1*50 + 3);
    chk("dead_no_hit", shot_hit, 0);
    cyc(1'b0, 1'b0, 0, 0);

    // column 7 removed: right edge uses column 6, descent at base_x=250
    cyc(1'b1, 1'b0, 0, 0);
    for (int r = 0; r < ROWS; r++) begin
      shoot(r * COLS + 7, 3, 3);
      cyc(1'b0, 1'b0, 0, 0);
    end
    for (int k = 0; k < 100 && !m_dir; k++) cyc(1'b0, 1'b0, 0, 0);
    chk("col7_desc_x", base_x, 250);
    chk("col7_desc_y", base_y, 65);
    chk("col7_count", alive_count, 21);

    // asynchronous reset mid-march
    #3 reset = 1'b0;
    #1;
    model_reset();
    chk("arst_base_x", base_x, 150);
    chk("arst_base_y", base_y, 40);
    chk("arst_alive", alive, 0);
    chk("arst_flags", {shot_hit, step, dir, wave_clear, invaded, hit_index}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 8; k++) cyc(1'b0, 1'b1, 150 + 3, 40 + 3);
    chk("idle_hold_x", base_x, 150);

    // randomized shots against the model
    cyc(1'b1, 1'b0, 0, 0);
    for (int k = 0; k < 600; k++) begin
      q.delete();
      for (int i = 0; i < N; i++) if (m_alive[i]) q.push_back(i);
      if ($urandom_range(0, 149) == 0) begin
        cyc(1'b1, 1'b0, 0, 0);
      end else if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
        start = 1'b0;
        cyc(1'b0, 1'($urandom_range(0, 1)),
            (m_bx + (q[$urandom_range(0, q.size() - 1)] % COLS) * DX + $urandom_range(0, SPR_W - 1)) % 2048,
            (m_by + (q[0] / COLS) * DY + $urandom_range(0, SPR_H - 1)) % 2048);
      end else begin
        cyc(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 700), $urandom_range(0, 500));
      end
    end

    // kill the whole wave: clear flag, no further movement, start restores
    cyc(1'b1, 1'b0, 0, 0);
    for (int k = 0; k < 300 && !m_clr; k++) begin
      q.delete();
      for (int i = 0; i < N; i++) if (m_alive[i]) q.push_back(i);
      if (m_hit || q.size() == 0) cyc(1'b0, 1'b0, 0, 0);
      else shoot(q[0], 5, 7);
    end
    chk("clear_flag", wave_clear, 1);
    chk("clear_count", alive_count, 0);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1'b0, 1'b0, 0, 0);
      seen += int'(step);
    end
    chk("clear_no_step", seen, 0);
    cyc(1'b1, 1'b0, 0, 0);
    chk("restart_alive", alive, 24'hFFFFFF);
    chk("restart_clear", wave_clear, 0);
    cyc(1'b0, 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
